// File: rtl/alien_fire_scheduler_pkg.sv
// Shared definitions for the alien fire scheduler: FSM encoding, random-word
// field offsets and default timing.
package alien_fire_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    PICK = 3'd3,
    FIRE = 3'd4
  } sched_state_e;

  // Bit positions inside the LFSR word for the delay spread and the start column.
  localparam int DELAY_LSB = 0;
  localparam int COL_LSB   = 8;

  localparam int DEFAULT_MIN_DELAY = 16;

endpackage : alien_fire_scheduler_pkg

// File: rtl/alien_fire_scheduler_fire_column_picker.sv
// Walks the alien columns from a random start, one probe per cycle, until it
// lands on a living column or has tried every column once.
module fire_column_picker
  import alien_fire_scheduler_pkg::*;
#(
  parameter int NUM_COLS = 8,
  parameter int COL_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                step_i,
  input  logic [COL_W-1:0]    rand_col_i,
  input  logic [NUM_COLS-1:0] alive_cols_i,
  output logic [COL_W-1:0]    col_o,
  output logic                found_o,
  output logic                exhausted_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [COL_W-1:0] probe_q, probe_d;
  logic             found;
  logic             exhausted;

  // alive_cols is tested live, so a column dying mid-search is respected.
  assign found     = alive_cols_i[col_q];
  assign exhausted = !found && (probe_q == COL_W'(NUM_COLS - 1));

  always_comb begin
    col_d   = col_q;
    probe_d = probe_q;
    if (start_i) begin
      col_d   = rand_col_i;
      probe_d = '0;
    end else if (step_i && !found && !exhausted) begin
      col_d   = col_q + COL_W'(1);
      probe_d = probe_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      probe_q <= '0;
    end else begin
      col_q   <= col_d;
      probe_q <= probe_d;
    end
  end

  assign col_o       = col_q;
  assign found_o     = found;
  assign exhausted_o = exhausted;

endmodule : fire_column_picker

// File: rtl/alien_fire_scheduler.sv
// Schedules alien shots: waits a random number of frame ticks, picks a random
// living column, then offers a valid/ready fire request to the bullet manager.
module alien_fire_scheduler
  import alien_fire_scheduler_pkg::*;
#(
  parameter int RAND_W     = 48,
  parameter int NUM_COLS   = 8,
  parameter int COL_W      = 3,
  parameter int DELAY_BITS = 6,
  parameter int MIN_DELAY  = DEFAULT_MIN_DELAY,
  parameter int CNT_W      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                frame_tick,
  input  logic [RAND_W-1:0]   random_number,
  input  logic [NUM_COLS-1:0] alive_cols,
  output logic                fire_valid,
  output logic [COL_W-1:0]    fire_col,
  input  logic                fire_ready,
  output logic [15:0]         fire_count
);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] fire_col_q, fire_col_d;
  logic [15:0]      fire_count_q, fire_count_d;
  logic             fire_valid_q;

  logic [CNT_W-1:0] load_value;
  logic             terminal_tick;
  logic             pick_start;
  logic             pick_step;
  logic [COL_W-1:0] pick_col;
  logic             pick_found;
  logic             pick_exhausted;
  logic             rand_unused;

  assign load_value = CNT_W'(MIN_DELAY) +
                      CNT_W'(random_number[DELAY_LSB +: DELAY_BITS]);

  // The counter reaching 1 on a tick means the loaded number of ticks has elapsed.
  assign terminal_tick = (state_q == WAIT) && enable && frame_tick &&
                         (cnt_q <= CNT_W'(1));
  assign pick_start    = terminal_tick;
  assign pick_step     = (state_q == PICK) && enable;
  assign rand_unused   = ^random_number;

  fire_column_picker #(
    .NUM_COLS (NUM_COLS),
    .COL_W    (COL_W)
  ) u_picker (
    .clk          (clk),
    .rst          (rst),
    .start_i      (pick_start),
    .step_i       (pick_step),
    .rand_col_i   (random_number[COL_LSB +: COL_W]),
    .alive_cols_i (alive_cols),
    .col_o        (pick_col),
    .found_o      (pick_found),
    .exhausted_o  (pick_exhausted)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fire_col_d   = fire_col_q;
    fire_count_d = fire_count_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = load_value;
        end
      end

      // Dropping enable wins over a tick arriving in the same cycle.
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (terminal_tick) begin
            state_d = PICK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      PICK: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pick_found) begin
          fire_col_d = pick_col;
          state_d    = FIRE;
        end else if (pick_exhausted) begin
          state_d = LOAD;
        end
      end

      // A pending request always completes; enable only chooses where to go after.
      FIRE: begin
        if (fire_ready) begin
          fire_count_d = fire_count_q + 16'd1;
          state_d      = enable ? LOAD : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fire_col_q   <= '0;
      fire_count_q <= '0;
      fire_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fire_col_q   <= fire_col_d;
      fire_count_q <= fire_count_d;
      fire_valid_q <= (state_d == FIRE);
    end
  end

  assign fire_valid = fire_valid_q;
  assign fire_col   = fire_col_q;
  assign fire_count = fire_count_q;

endmodule : alien_fire_scheduler
